// File: rtl/complex_fir_data_streamer_pkg.sv
// rtl/complex_fir_data_streamer_pkg.sv - shared defaults and FSM encoding for the complex FIR data path
package complex_fir_data_streamer_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 8;
  localparam int DEFAULT_NUM_SAMPLES   = 28;
  localparam int DEFAULT_FILTER_LENGTH = 12;
  localparam int DEFAULT_LEAD_CYCLES   = 5;

  // Per-state cycle counter; wide enough for LEAD_CYCLES, NUM_SAMPLES and FILTER_LENGTH.
  localparam int CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD   = 3'd1,
    STREAM = 3'd2,
    PAD    = 3'd3,
    STOP   = 3'd4
  } streamState_e;

endpackage

// File: rtl/complex_fir_data_streamer_ram.sv
// rtl/complex_fir_data_streamer_ram.sv - complex sample buffer with registered, zero-when-idle read port
module complex_sample_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 28,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wrEnable,
  input  logic [ADDR_WIDTH-1:0]        wrAddr,
  input  logic signed [DATA_WIDTH-1:0] wrDataRe,
  input  logic signed [DATA_WIDTH-1:0] wrDataIm,
  input  logic                         rdEnable,
  input  logic [ADDR_WIDTH-1:0]        rdAddr,
  output logic signed [DATA_WIDTH-1:0] rdDataRe,
  output logic signed [DATA_WIDTH-1:0] rdDataIm
);

  logic [2*DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; storage is never reset so contents survive an abort.
  always_ff @(posedge clock) begin
    if (wrEnable) begin
      mem[wrAddr] <= {wrDataRe, wrDataIm};
    end
  end

  // Read register doubles as the streamer's data output, so it reads zero when not enabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdDataRe <= '0;
      rdDataIm <= '0;
    end else if (rdEnable) begin
      {rdDataRe, rdDataIm} <= mem[rdAddr];
    end else begin
      rdDataRe <= '0;
      rdDataIm <= '0;
    end
  end

endmodule

// File: rtl/complex_fir_data_streamer.sv
// rtl/complex_fir_data_streamer.sv - streams buffered complex samples into a FIR with lead zeros and tail padding
module complex_fir_data_streamer
  import complex_fir_data_streamer_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int NUM_SAMPLES   = DEFAULT_NUM_SAMPLES,
  parameter int FILTER_LENGTH = DEFAULT_FILTER_LENGTH,
  parameter int LEAD_CYCLES   = DEFAULT_LEAD_CYCLES
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wrEnable,
  input  logic [$clog2(NUM_SAMPLES)-1:0] wrAddr,
  input  logic signed [DATA_WIDTH-1:0]   wrDataRe,
  input  logic signed [DATA_WIDTH-1:0]   wrDataIm,
  input  logic                           start,
  output logic                           loadDataFlag,
  output logic                           stopDataLoadFlag,
  output logic signed [DATA_WIDTH-1:0]   dataOutRe,
  output logic signed [DATA_WIDTH-1:0]   dataOutIm,
  output logic                           busy,
  output logic                           done
);

  localparam int ADDR_WIDTH = $clog2(NUM_SAMPLES);

  streamState_e         state, nextState;
  logic [CNT_WIDTH-1:0] cnt, nextCnt;
  logic                 nextLoad, nextStop, nextBusy;
  logic                 ramWrEnable, ramRdEnable;
  logic                 addrInRange;

  // State and per-state counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // Next-state logic; the counter restarts from zero on every state change.
  always_comb begin
    nextState = state;
    nextCnt   = cnt + CNT_WIDTH'(1);
    case (state)
      IDLE: begin
        nextCnt = '0;
        if (start) nextState = LEAD;
      end
      LEAD: begin
        if (cnt == CNT_WIDTH'(LEAD_CYCLES - 1)) begin
          nextState = STREAM;
          nextCnt   = '0;
        end
      end
      STREAM: begin
        if (cnt == CNT_WIDTH'(NUM_SAMPLES - 1)) begin
          nextState = (FILTER_LENGTH > 1) ? PAD : STOP;
          nextCnt   = '0;
        end
      end
      PAD: begin
        if (cnt == CNT_WIDTH'(FILTER_LENGTH - 2)) begin
          nextState = STOP;
          nextCnt   = '0;
        end
      end
      default: begin
        nextState = IDLE;
        nextCnt   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so every output lands in a register on the same edge as the state.
  always_comb begin
    nextLoad    = (nextState == LEAD) || (nextState == STREAM) || (nextState == PAD);
    nextStop    = (nextState == STOP);
    nextBusy    = (nextState != IDLE);
    ramRdEnable = (nextState == STREAM);
  end

  // Flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      loadDataFlag     <= 1'b0;
      stopDataLoadFlag <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      loadDataFlag     <= nextLoad;
      stopDataLoadFlag <= nextStop;
      busy             <= nextBusy;
      done             <= nextStop;
    end
  end

  assign addrInRange = ({1'b0, wrAddr} < (ADDR_WIDTH + 1)'(NUM_SAMPLES));
  assign ramWrEnable = wrEnable && !reset && (state == IDLE) && addrInRange;

  // Read address is the upcoming sample index, fetched one edge before it must appear.
  complex_sample_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NUM_SAMPLES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) sampleRam (
    .clock    (clock),
    .reset    (reset),
    .wrEnable (ramWrEnable),
    .wrAddr   (wrAddr),
    .wrDataRe (wrDataRe),
    .wrDataIm (wrDataIm),
    .rdEnable (ramRdEnable),
    .rdAddr   (nextCnt[ADDR_WIDTH-1:0]),
    .rdDataRe (dataOutRe),
    .rdDataIm (dataOutIm)
  );

endmodule

// File: tb/tb_complex_fir_data_streamer.sv
// tb/tb_complex_fir_data_streamer.sv - directed self-checking bench for complex_fir_data_streamer
module tb_complex_fir_data_streamer;

  localparam int L = 5;
  localparam int N = 28;
  localparam int F = 12;

  logic              clock = 1'b0;
  logic              reset;
  logic              wrEnable;
  logic [4:0]        wrAddr;
  logic signed [7:0] wrDataRe, wrDataIm;
  logic              start;
  logic              loadDataFlag, stopDataLoadFlag, busy, done;
  logic signed [7:0] dataOutRe, dataOutIm;

  logic [7:0] modelRe [N];
  logic [7:0] modelIm [N];

  int assertCount = 0;
  int failCount   = 0;

  complex_fir_data_streamer dut (
    .clock            (clock),
    .reset            (reset),
    .wrEnable         (wrEnable),
    .wrAddr           (wrAddr),
    .wrDataRe         (wrDataRe),
    .wrDataIm         (wrDataIm),
    .start            (start),
    .loadDataFlag     (loadDataFlag),
    .stopDataLoadFlag (stopDataLoadFlag),
    .dataOutRe        (dataOutRe),
    .dataOutIm        (dataOutIm),
    .busy             (busy),
    .done             (done)
  );

  always #5 clock = ~clock;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] outVec();
    return 32'({loadDataFlag, stopDataLoadFlag, done, busy, dataOutRe, dataOutIm});
  endfunction

  task automatic writeSample(input logic [4:0] addr, input logic [7:0] re, input logic [7:0] im, input bit store);
    wrEnable = 1'b1;
    wrAddr   = addr;
    wrDataRe = re;
    wrDataIm = im;
    @(posedge clock); #1;
    wrEnable = 1'b0;
    if (store) begin
      modelRe[addr] = re;
      modelIm[addr] = im;
    end
  endtask

  // c counts cycles after the edge that samples start; c == L+N+F-1 is STOP, c == L+N+F is back in IDLE.
  task automatic runSequence(input string tag, input int abortCycle, input int writeCycle, input bit holdStart);
    int total, loadCount, doneCount;
    logic exLoad, exStop, exBusy;
    logic [7:0] exRe, exIm;
    total     = L + N + F;
    loadCount = 0;
    doneCount = 0;
    start = 1'b1;
    @(posedge clock); #1;
    if (!holdStart) start = 1'b0;
    for (int c = 0; c <= total; c++) begin
      exLoad = (c < total - 1);
      exStop = (c == total - 1);
      exBusy = (c <= total - 1);
      exRe   = (c >= L && c < L + N) ? modelRe[c - L] : 8'h00;
      exIm   = (c >= L && c < L + N) ? modelIm[c - L] : 8'h00;
      checkValue($sformatf("%s c%0d", tag, c), outVec(), 32'({exLoad, exStop, exStop, exBusy, exRe, exIm}));
      if (loadDataFlag) loadCount++;
      if (done) doneCount++;
      if (c == abortCycle) begin
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checkValue({tag, " abort"}, outVec(), 32'h0);
        return;
      end
      if (c == writeCycle) begin
        wrEnable = 1'b1;
        wrAddr   = 5'd0;
        wrDataRe = 8'sd99;
        wrDataIm = -8'sd69;
      end else begin
        wrEnable = 1'b0;
      end
      if (c < total) begin
        @(posedge clock); #1;
      end
    end
    checkValue({tag, " loadCount"}, 32'(loadCount), 32'(L + N + F - 1));
    checkValue({tag, " doneCount"}, 32'(doneCount), 32'd1);
  endtask

  initial begin
    reset    = 1'b1;
    wrEnable = 1'b0;
    wrAddr   = '0;
    wrDataRe = '0;
    wrDataIm = '0;
    start    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkValue("reset state", outVec(), 32'h0);
    reset = 1'b0;

    writeSample(5'd0, 8'sd2, 8'sd3, 1'b1);
    writeSample(5'd1, 8'sd5, 8'sd10, 1'b1);
    writeSample(5'd2, -8'sd2, -8'sd3, 1'b1);
    for (int i = 3; i < N; i++) begin
      writeSample(5'(i), 8'(i + 10), 8'(100 - i), 1'b1);
    end
    runSequence("default", -1, -1, 1'b0);

    reset    = 1'b1;
    start    = 1'b1;
    wrEnable = 1'b1;
    wrAddr   = 5'd3;
    wrDataRe = 8'sd77;
    wrDataIm = 8'sd77;
    @(posedge clock); #1;
    reset    = 1'b0;
    start    = 1'b0;
    wrEnable = 1'b0;
    checkValue("reset priority", outVec(), 32'h0);

    runSequence("abort", L + 9, -1, 1'b0);
    runSequence("replay", -1, -1, 1'b0);

    runSequence("write in stream", -1, L + 3, 1'b0);
    runSequence("after ignored write", -1, -1, 1'b0);

    wrEnable = 1'b1;
    wrAddr   = 5'd0;
    wrDataRe = 8'sd56;
    wrDataIm = -8'sd39;
    modelRe[0] = 8'sd56;
    modelIm[0] = -8'sd39;
    runSequence("write with start", -1, -1, 1'b0);

    writeSample(5'd1, -8'sd128, 8'sd127, 1'b1);
    writeSample(5'd2, 8'sd127, -8'sd128, 1'b1);
    writeSample(5'd28, 8'sd11, 8'sd22, 1'b0);
    runSequence("boundary", -1, -1, 1'b0);

    runSequence("held start 1", -1, -1, 1'b1);
    runSequence("held start 2", -1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
